// File: rtl/emulador_teclado.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : emulador_teclado                                             |
// | Description : 4x4 keypad column emulator; presses one key for a hold time, |
// |               forces a release gap, then acks. Define EMULADOR_REBOTE_EN   |
// |               to add contact bounce at the start of each press.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module emulador_teclado #(
    parameter int HOLD_CYCLES   = 2_500_000,
    parameter int GAP_CYCLES    = 1_250_000,
    parameter int CNT_W         = 22,
    parameter int BOUNCE_CYCLES = 50_000,
    parameter int BOUNCE_PERIOD = 5_000
) (
    input  logic       CLOCK_50_in,
    input  logic       RESET_N_in,
    input  logic [3:0] barrido_in,
    input  logic [3:0] tecla_in,
    input  logic       req_in,
    output logic       busy_out,
    output logic       presionada_out,
    output logic       ack_out,
    output logic [3:0] GPIO_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Zero-length hold/gap collapse to a single cycle.
    localparam logic [CNT_W-1:0] c_hold_lim = (HOLD_CYCLES > 1) ? CNT_W'(HOLD_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] c_gap_lim  = (GAP_CYCLES > 1)  ? CNT_W'(GAP_CYCLES - 1)  : '0;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_tecla;
    logic             r_busy;
    logic             r_pres;
    logic             r_ack;
    logic [3:0]       r_gpio;
    logic             w_gate;
    logic [3:0]       w_gpio_nxt;

`ifdef EMULADOR_REBOTE_EN
    localparam logic [CNT_W-1:0] c_bounce_len = CNT_W'(BOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_bper_lim   = (BOUNCE_PERIOD > 1) ? CNT_W'(BOUNCE_PERIOD - 1) : '0;

    logic [CNT_W-1:0] r_bcnt;
    logic             r_bwave;

    // Square wave starts closed and toggles every BOUNCE_PERIOD cycles of PRESS.
    always_ff @(posedge CLOCK_50_in) begin
        if (!RESET_N_in) begin
            r_bcnt  <= '0;
            r_bwave <= 1'b1;
        end else if (r_state == ST_IDLE) begin
            r_bcnt  <= '0;
            r_bwave <= 1'b1;
        end else if (r_state == ST_PRESS) begin
            if (r_bcnt >= c_bper_lim) begin
                r_bcnt  <= '0;
                r_bwave <= ~r_bwave;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    assign w_gate = (r_cnt >= c_bounce_len) || r_bwave;
`else
    // Bounce settings only take effect with the macro defined.
    localparam int c_unused_bounce = BOUNCE_CYCLES + BOUNCE_PERIOD;

    assign w_gate = 1'b1;
`endif

    always_comb begin
        w_gpio_nxt = '0;
        if (r_state == ST_PRESS) begin
            w_gpio_nxt[r_tecla[1:0]] = barrido_in[r_tecla[3:2]] & w_gate;
        end
    end

    always_ff @(posedge CLOCK_50_in) begin
        if (!RESET_N_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tecla <= '0;
            r_busy  <= 1'b0;
            r_pres  <= 1'b0;
            r_ack   <= 1'b0;
            r_gpio  <= '0;
        end else begin
            r_ack  <= 1'b0;
            r_gpio <= w_gpio_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (req_in) begin
                        r_state <= ST_PRESS;
                        r_tecla <= tecla_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_pres  <= 1'b1;
                    end
                end
                ST_PRESS: begin
                    if (r_cnt >= c_hold_lim) begin
                        r_state <= ST_GAP;
                        r_cnt   <= '0;
                        r_pres  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    // busy stays high through the ack cycle; IDLE clears it next.
                    if (r_cnt >= c_gap_lim) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_pres  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_out       = r_busy;
    assign presionada_out = r_pres;
    assign ack_out        = r_ack;
    assign GPIO_out       = r_gpio;

endmodule
`default_nettype wire
